axi_err_slave: RTL and testbench

- Parametrised AXI3-style default/error slave for unmapped address regions on the CPU-side interconnect.
- Next generation of the fixed 128-bit error slave. Generalised in data, ID and address widths.
- Read and write channels run concurrently and independently. Response code is programmable (DECERR by default).
- Adds programmable read latency, wlast-mismatch detection, an error-event counter and first-error address capture for software/debug visibility.

---
 rtl/axi_err_slave.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi_err_slave.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_err_slave.sv
// rtl/axi_err_slave.sv - AXI3 default/error slave with programmable response, read latency and error capture
module axi_err_slave #(
  parameter int unsigned       DATA_W = 128,
  parameter int unsigned       ID_W   = 8,
  parameter int unsigned       ADDR_W = 40,
  parameter logic [1:0]        RESP   = 2'b11,
  parameter int unsigned       RD_LAT = 1,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input  logic                  pll_core_cpuclk,
  input  logic                  pad_cpu_rst_b,

  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic [3:0]            arcache,
  input  logic [2:0]            arprot,

  output logic                  rvalid,
  input  logic                  rready,
  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,

  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic [3:0]            awcache,
  input  logic [2:0]            awprot,

  input  logic                  wvalid,
  output logic                  wready,
  input  logic [ID_W-1:0]       wid,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,

  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,

  input  logic                  err_clr,
  output logic [15:0]           err_cnt,
  output logic [ADDR_W-1:0]     err_addr,
  output logic                  err_addr_vld,
  output logic                  wlast_err
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("axi_err_slave: RD_LAT must be within 1..15");
  end
  if (DATA_W != 32 && DATA_W != 64 && DATA_W != 128 && DATA_W != 256) begin : g_bad_data_w
    $error("axi_err_slave: DATA_W must be 32, 64, 128 or 256");
  end

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // Burst attributes and payload are irrelevant to an error responder.
  logic unused_inputs;
  assign unused_inputs = ^{arsize, arburst, arcache, arprot, awsize, awburst,
                           awcache, awprot, wid, wdata, wstrb};

  rd_state_e         rd_state_q;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic [7:0]        rlen_q;
  logic [7:0]        beat_cnt_q;
  logic [7:0]        beat_nxt;
  logic [3:0]        lat_cnt_q;
  logic              ar_hs;

  assign ar_hs    = arready_q & arvalid;
  assign beat_nxt = beat_cnt_q + 8'd1;

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      rlen_q     <= 8'd0;
      beat_cnt_q <= 8'd0;
      lat_cnt_q  <= 4'd0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q  <= 1'b0;
            rid_q      <= arid;
            rlen_q     <= arlen;
            lat_cnt_q  <= 4'(RD_LAT - 1);
            rd_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (lat_cnt_q == 4'd0) begin
            rvalid_q   <= 1'b1;
            rlast_q    <= (rlen_q == 8'd0);
            rdata_q    <= FILL;
            rresp_q    <= RESP;
            beat_cnt_q <= 8'd0;
            rd_state_q <= R_DATA;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast_q) begin
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
              arready_q  <= 1'b1;
              rd_state_q <= R_IDLE;
            end else begin
              beat_cnt_q <= beat_nxt;
              rlast_q    <= (beat_nxt == rlen_q);
            end
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  wr_state_e       wr_state_q;
  logic            awready_q;
  logic            wready_q;
  logic            bvalid_q;
  logic [ID_W-1:0] bid_q;
  logic [1:0]      bresp_q;
  logic [7:0]      wlen_q;
  logic [7:0]      wbeat_cnt_q;
  logic            aw_hs;
  logic            w_hs;
  logic            w_final;
  logic            wlast_mis;

  assign aw_hs     = awready_q & awvalid;
  assign w_hs      = wready_q & wvalid;
  assign w_final   = (wbeat_cnt_q == wlen_q);
  assign wlast_mis = w_hs & (wlast ^ w_final);

  // Completion follows the awlen beat count; wlast only feeds the sticky flag.
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      wr_state_q  <= W_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= 2'b00;
      wlen_q      <= 8'd0;
      wbeat_cnt_q <= 8'd0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            awready_q   <= 1'b0;
            wready_q    <= 1'b1;
            bid_q       <= awid;
            wlen_q      <= awlen;
            wbeat_cnt_q <= 8'd0;
            wr_state_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (w_final) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bresp_q    <= RESP;
              wr_state_q <= W_RESP;
            end else begin
              wbeat_cnt_q <= wbeat_cnt_q + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              err_addr_vld_q, err_addr_vld_d;
  logic              wlast_err_q, wlast_err_d;
  logic [1:0]        hs_inc;
  logic [16:0]       cnt_sum;

  assign hs_inc  = {1'b0, ar_hs} + {1'b0, aw_hs};
  assign cnt_sum = {1'b0, err_cnt_q} + {15'd0, hs_inc};

  // Clear wins over both counting and capture in the same cycle.
  always_comb begin
    err_cnt_d      = err_cnt_q;
    err_addr_d     = err_addr_q;
    err_addr_vld_d = err_addr_vld_q;
    wlast_err_d    = wlast_err_q;
    if (err_clr) begin
      err_cnt_d      = 16'd0;
      err_addr_vld_d = 1'b0;
      wlast_err_d    = 1'b0;
    end else begin
      err_cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      wlast_err_d = wlast_err_q | wlast_mis;
      if (!err_addr_vld_q && (ar_hs || aw_hs)) begin
        err_addr_d     = ar_hs ? araddr : awaddr;
        err_addr_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      err_cnt_q      <= 16'd0;
      err_addr_q     <= '0;
      err_addr_vld_q <= 1'b0;
      wlast_err_q    <= 1'b0;
    end else begin
      err_cnt_q      <= err_cnt_d;
      err_addr_q     <= err_addr_d;
      err_addr_vld_q <= err_addr_vld_d;
      wlast_err_q    <= wlast_err_d;
    end
  end

  assign arready      = arready_q;
  assign rvalid       = rvalid_q;
  assign rid          = rid_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign rlast        = rlast_q;
  assign awready      = awready_q;
  assign wready       = wready_q;
  assign bvalid       = bvalid_q;
  assign bid          = bid_q;
  assign bresp        = bresp_q;
  assign err_cnt      = err_cnt_q;
  assign err_addr     = err_addr_q;
  assign err_addr_vld = err_addr_vld_q;
  assign wlast_err    = wlast_err_q;

endmodule

// File: tb/tb_axi_err_slave.sv
// tb/tb_axi_err_slave.sv - randomized and directed bench for axi_err_slave against a transaction-level model
module tb_axi_err_slave;
  localparam int DATA_W = 128;
  localparam int ID_W   = 8;
  localparam int ADDR_W = 40;
  localparam int RD_LAT = 1;
  localparam logic [1:0] RESP = 2'b11;
  localparam logic [DATA_W-1:0] FILL = '0;

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  logic arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0, err_clr = 1'b0;
  logic [7:0] arid = '0, awid = '0, wid = '0, arlen = '0, awlen = '0;
  logic [39:0] araddr = '0, awaddr = '0;
  logic [2:0] arsize = '0, arprot = '0, awsize = '0, awprot = '0;
  logic [1:0] arburst = '0, awburst = '0;
  logic [3:0] arcache = '0, awcache = '0;
  logic [127:0] wdata = '0;
  logic [15:0] wstrb = '0;
  logic arready, rvalid, rlast, awready, wready, bvalid, err_addr_vld, wlast_err;
  logic [7:0] rid, bid;
  logic [127:0] rdata;
  logic [1:0] rresp, bresp;
  logic [15:0] err_cnt;
  logic [39:0] err_addr;

  always #5 clk = ~clk;

  axi_err_slave #(.DATA_W(DATA_W), .ID_W(ID_W), .ADDR_W(ADDR_W), .RESP(RESP), .RD_LAT(RD_LAT), .FILL(FILL)) dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arcache(arcache), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awcache(awcache), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .err_clr(err_clr), .err_cnt(err_cnt), .err_addr(err_addr), .err_addr_vld(err_addr_vld), .wlast_err(wlast_err)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Transaction-level model: per-channel outstanding burst, beats done, handshake timestamp.
  bit m_up = 1'b0, rd_busy = 1'b0, wr_busy = 1'b0, wr_resp = 1'b0;
  int rd_len = 0, rd_beats = 0, rd_hs = 0, wr_len = 0, wr_beats = 0, edge_n = 0, m_cnt = 0;
  logic [7:0] rd_id = '0, wr_id = '0;
  logic [39:0] m_addr = '0;
  bit m_vld = 1'b0, m_werr = 1'b0;
  bit ar_hs, r_hs, aw_hs, w_hs, b_hs, w_bad;

  function automatic bit e_arready(); return m_up && !rd_busy; endfunction
  function automatic bit e_awready(); return m_up && !wr_busy; endfunction
  function automatic bit e_rvalid(); return rd_busy && (edge_n - rd_hs >= RD_LAT); endfunction
  function automatic bit e_wready(); return wr_busy && !wr_resp; endfunction

  initial forever begin
    @(posedge clk or negedge rst_b);
    if (!rst_b) begin
      m_up = 0; rd_busy = 0; rd_beats = 0; wr_busy = 0; wr_resp = 0; wr_beats = 0;
      m_cnt = 0; m_addr = '0; m_vld = 0; m_werr = 0;
    end else begin
      ar_hs = e_arready() && arvalid;
      r_hs  = e_rvalid() && rready;
      aw_hs = e_awready() && awvalid;
      w_hs  = e_wready() && wvalid;
      b_hs  = wr_resp && bready;
      w_bad = w_hs && (wlast != (wr_beats == wr_len));
      edge_n++;
      if (r_hs) begin
        rd_beats++;
        if (rd_beats == rd_len + 1) rd_busy = 0;
      end
      if (ar_hs) begin
        rd_busy = 1; rd_id = arid; rd_len = int'(arlen); rd_beats = 0; rd_hs = edge_n;
      end
      if (w_hs) begin
        wr_beats++;
        if (wr_beats == wr_len + 1) wr_resp = 1;
      end
      if (b_hs) begin wr_busy = 0; wr_resp = 0; end
      if (aw_hs) begin
        wr_busy = 1; wr_resp = 0; wr_id = awid; wr_len = int'(awlen); wr_beats = 0;
      end
      if (err_clr) begin
        m_cnt = 0; m_vld = 0; m_werr = 0;
      end else begin
        m_cnt = m_cnt + int'(ar_hs) + int'(aw_hs);
        if (m_cnt > 65535) m_cnt = 65535;
        if (!m_vld && (ar_hs || aw_hs)) begin
          m_addr = ar_hs ? araddr : awaddr;
          m_vld = 1;
        end
        if (w_bad) m_werr = 1;
      end
      m_up = 1;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  task automatic compare_all();
    chk("arready", 256'(arready), 256'(e_arready()));
    chk("awready", 256'(awready), 256'(e_awready()));
    chk("rvalid", 256'(rvalid), 256'(e_rvalid()));
    chk("wready", 256'(wready), 256'(e_wready()));
    chk("bvalid", 256'(bvalid), 256'(wr_resp));
    chk("err_cnt", 256'(err_cnt), 256'(m_cnt[15:0]));
    chk("err_addr", 256'(err_addr), 256'(m_addr));
    chk("err_addr_vld", 256'(err_addr_vld), 256'(m_vld));
    chk("wlast_err", 256'(wlast_err), 256'(m_werr));
    if (e_rvalid()) begin
      chk("rid", 256'(rid), 256'(rd_id));
      chk("rdata", 256'(rdata), 256'(FILL));
      chk("rresp", 256'(rresp), 256'(RESP));
      chk("rlast", 256'(rlast), 256'(rd_beats == rd_len));
    end
    if (wr_resp) begin
      chk("bid", 256'(bid), 256'(wr_id));
      chk("bresp", 256'(bresp), 256'(RESP));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_en) compare_all();
  end

  initial begin
    #1400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    arvalid = 0; awvalid = 0; wvalid = 0; wlast = 0; rready = 0; bready = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_b = 0;
    repeat (3) @(negedge clk);
    #2 rst_b = 1;
    @(negedge clk);
  endtask

  task automatic wait_ar();
    int g = 0;
    while (!e_arready() && g < 300) begin @(negedge clk); g++; end
    if (!e_arready()) fail_to("wait_arready");
  endtask

  task automatic wait_both();
    int g = 0;
    while (!(e_arready() && e_awready()) && g < 300) begin @(negedge clk); g++; end
    if (!(e_arready() && e_awready())) fail_to("wait_ar_aw_ready");
  endtask

  task automatic do_write(input logic [7:0] id, input bit early_last, output int nb);
    int g = 0;
    int w = 0;
    while (!e_awready() && w < 300) begin @(negedge clk); w++; end
    if (!e_awready()) fail_to("wait_awready");
    awvalid = 1; awid = id; awlen = 8'd1; awaddr = 40'h00_0000_8000; bready = 1;
    @(negedge clk);
    awvalid = 0;
    nb = 0;
    while (!bvalid && g < 40) begin
      if (wready) begin
        wvalid = 1; wlast = early_last ? 1'b1 : (nb == 1); nb++;
      end else begin
        wvalid = 0;
      end
      @(negedge clk);
      g++;
    end
    wvalid = 0; wlast = 0;
    if (!bvalid) fail_to("write_bvalid");
  endtask

  initial begin
    int beats, nlast, last_at, g, nb;
    bit tog, ar_seen;

    idle_inputs();
    #1 rst_b = 0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk("rst_arready", 256'(arready), 256'(1'b0));
    chk("rst_awready", 256'(awready), 256'(1'b0));
    chk("rst_rvalid", 256'(rvalid), 256'(1'b0));
    chk("rst_rresp", 256'(rresp), 256'(2'b00));
    chk("rst_err_cnt", 256'(err_cnt), 256'(16'd0));
    #2 rst_b = 1;
    @(negedge clk);
    chk("arready_after_rst", 256'(arready), 256'(1'b1));

    // Single-beat read, RD_LAT=1.
    rready = 1; arvalid = 1; arid = 8'h5A; arlen = 8'd0; araddr = 40'h00_1234_5000;
    @(negedge clk);
    arvalid = 0;
    chk("single_rvalid_c1", 256'(rvalid), 256'(1'b0));
    @(negedge clk);
    chk("single_rvalid_c2", 256'(rvalid), 256'(1'b1));
    chk("single_rid", 256'(rid), 256'(8'h5A));
    chk("single_rresp", 256'(rresp), 256'(2'b11));
    chk("single_rlast", 256'(rlast), 256'(1'b1));
    chk("single_rdata", 256'(rdata), 256'(128'd0));
    @(negedge clk);
    chk("single_done_rvalid", 256'(rvalid), 256'(1'b0));
    chk("single_done_arready", 256'(arready), 256'(1'b1));
    chk("single_err_addr", 256'(err_addr), 256'(40'h00_1234_5000));
    chk("single_err_cnt", 256'(err_cnt), 256'(16'd1));
    rready = 0;

    // arlen=3 burst with rready toggling.
    wait_ar();
    arvalid = 1; arid = 8'hA1; arlen = 8'd3;
    @(negedge clk);
    arvalid = 0;
    beats = 0; nlast = 0; last_at = 0; g = 0; tog = 1; ar_seen = 0;
    while (beats < 4 && g < 60) begin
      if (arready) ar_seen = 1;
      if (rvalid) begin
        rready = tog;
        if (tog) begin
          beats++;
          if (rlast) begin nlast++; last_at = beats; end
        end
        tog = !tog;
      end else begin
        rready = 0;
      end
      @(negedge clk);
      g++;
    end
    rready = 0;
    chk("burst_beats", 256'(beats), 256'(4));
    chk("burst_nlast", 256'(nlast), 256'(1));
    chk("burst_last_at", 256'(last_at), 256'(4));
    chk("burst_arready_busy", 256'(ar_seen), 256'(1'b0));
    chk("burst_arready_after", 256'(arready), 256'(1'b1));

    // Writes: correct wlast, then early wlast.
    do_write(8'h33, 1'b0, nb);
    chk("wr_beats", 256'(nb), 256'(2));
    chk("wr_bid", 256'(bid), 256'(8'h33));
    chk("wr_bresp", 256'(bresp), 256'(2'b11));
    chk("wr_wlast_err", 256'(wlast_err), 256'(1'b0));
    @(negedge clk);
    do_write(8'h44, 1'b1, nb);
    chk("wr_early_beats", 256'(nb), 256'(2));
    chk("wr_early_wlast_err", 256'(wlast_err), 256'(1'b1));
    @(negedge clk);
    bready = 0;
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("clr_wlast_err", 256'(wlast_err), 256'(1'b0));
    chk("clr_err_cnt", 256'(err_cnt), 256'(16'd0));

    // Simultaneous AR and AW fresh after reset.
    do_reset();
    arvalid = 1; araddr = 40'h10_0000_0000; arlen = 8'd0; arid = 8'h11;
    awvalid = 1; awaddr = 40'h20_0000_0000; awlen = 8'd0; awid = 8'h22;
    rready = 1; bready = 0; wvalid = 1; wlast = 1;
    @(negedge clk);
    arvalid = 0; awvalid = 0;
    chk("sim_err_cnt", 256'(err_cnt), 256'(16'd2));
    chk("sim_err_addr", 256'(err_addr), 256'(40'h10_0000_0000));
    chk("sim_err_addr_vld", 256'(err_addr_vld), 256'(1'b1));
    beats = 0;
    repeat (5) begin
      @(negedge clk);
      wvalid = 0;
      if (rvalid && rready) beats++;
    end
    chk("sim_read_beats", 256'(beats), 256'(1));
    chk("sim_bvalid_held", 256'(bvalid), 256'(1'b1));
    bready = 1;
    @(negedge clk);
    chk("sim_bvalid_done", 256'(bvalid), 256'(1'b0));
    idle_inputs();

    // Reset in the middle of an 8-beat read.
    wait_ar();
    arvalid = 1; arlen = 8'd7; arid = 8'h77; rready = 1;
    @(negedge clk);
    arvalid = 0;
    beats = 0; g = 0;
    while (beats < 3 && g < 50) begin
      @(negedge clk);
      if (rvalid) beats++;
      g++;
    end
    @(negedge clk);
    #2 rst_b = 0;
    #1 chk("rst_mid_rvalid", 256'(rvalid), 256'(1'b0));
    repeat (2) @(negedge clk);
    #2 rst_b = 1;
    @(negedge clk);
    chk("rst_mid_arready", 256'(arready), 256'(1'b1));
    chk("rst_mid_err_cnt", 256'(err_cnt), 256'(16'd0));
    beats = 0;
    repeat (5) begin
      @(negedge clk);
      if (rvalid) beats++;
    end
    chk("rst_mid_stale_beats", 256'(beats), 256'(0));
    rready = 0;

    // Random traffic on all channels.
    for (int i = 0; i < 800; i++) begin
      arvalid = ($urandom_range(0, 2) == 0);
      arid    = 8'($urandom);
      araddr  = {8'($urandom), $urandom};
      arlen   = 8'($urandom_range(0, 5));
      awvalid = ($urandom_range(0, 2) == 0);
      awid    = 8'($urandom);
      awaddr  = {8'($urandom), $urandom};
      awlen   = 8'($urandom_range(0, 5));
      wvalid  = ($urandom_range(0, 9) < 7);
      wlast   = ($urandom_range(0, 9) < 8) ? (wr_beats == wr_len) : (wr_beats != wr_len);
      wdata   = {$urandom, $urandom, $urandom, $urandom};
      wstrb   = 16'($urandom);
      rready  = ($urandom_range(0, 9) < 7);
      bready  = ($urandom_range(0, 1) == 0);
      err_clr = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    idle_inputs();

    // Saturation: concurrent AR+AW stream up to 0xFFFE, then three more.
    do_reset();
    arvalid = 1; awvalid = 1; arlen = 8'd0; awlen = 8'd0;
    wvalid = 1; wlast = 1; rready = 1; bready = 1;
    g = 0;
    while (m_cnt < 65534 && g < 100000) begin @(negedge clk); g++; end
    arvalid = 0; awvalid = 0;
    if (m_cnt < 65534) fail_to("saturation_preload");
    chk("sat_preload", 256'(err_cnt), 256'(16'hFFFE));
    wait_ar();
    arvalid = 1;
    @(negedge clk);
    arvalid = 0;
    chk("sat_ffff", 256'(err_cnt), 256'(16'hFFFF));
    wait_both();
    arvalid = 1; awvalid = 1;
    @(negedge clk);
    arvalid = 0; awvalid = 0;
    chk("sat_hold", 256'(err_cnt), 256'(16'hFFFF));
    wait_ar();
    arvalid = 1; err_clr = 1;
    @(negedge clk);
    arvalid = 0; err_clr = 0;
    chk("clr_with_ar_cnt", 256'(err_cnt), 256'(16'd0));
    chk("clr_with_ar_vld", 256'(err_addr_vld), 256'(1'b0));
    repeat (4) @(negedge clk);
    idle_inputs();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
